// File: rtl/fp_norm_pkg.sv
// Shared encodings and width helpers for the FMUL normalise/round back end.
package fp_norm_pkg;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } cls_e;

    typedef enum logic [1:0] {
        RND_RNE = 2'b00,
        RND_RTZ = 2'b01,
        RND_RUP = 2'b10,
        RND_RDN = 2'b11
    } rnd_e;

    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_INX  = 1;
    localparam int FLG_ZERO = 0;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int prod_w(input int frac_w);
        return 2 * (frac_w + 1);
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Counts leading zeros of a vector; an all-zero input returns DATA_W.
module leading_zero_counter #(
    parameter  int DATA_W = 48,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        count = CNT_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) count = CNT_W'(DATA_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Three-stage normalise-and-round back end: S1 lzc, S2 align/denormalise, S3 round/pack.
module fp_norm_round_pipe
    import fp_norm_pkg::*;
#(
    parameter  int EXP_W  = 8,
    parameter  int FRAC_W = 23,
    localparam int PROD_W = prod_w(FRAC_W),
    localparam int RES_W  = 1 + EXP_W + FRAC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W+1:0]    in_exp,
    input  logic [PROD_W-1:0]   in_mant,
    input  logic [1:0]          in_class,
    input  logic [1:0]          in_rnd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    out_result,
    output logic [3:0]          out_flags
);

    localparam int STAGES = 3;
    localparam int EW     = EXP_W + 2;
    localparam int IW     = EXP_W + 3;   // one extra bit so in_exp+1 and -in_exp never wrap
    localparam int LZ_W   = $clog2(PROD_W + 1);
    localparam int RS_W   = $clog2(PROD_W + 2);
    localparam logic signed [IW-1:0] MAX_E = IW'((1 << EXP_W) - 1);

    logic [STAGES:1] vld_pipe;
    logic            adv;

    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // ---------------- S1 ----------------
    logic [LZ_W-1:0]         lz_in;
    cls_e                    cls_in;
    logic                    s1_sign;
    logic signed [EW-1:0]    s1_exp;
    logic [PROD_W-1:0]       s1_mant;
    cls_e                    s1_cls;
    rnd_e                    s1_rnd;
    logic [LZ_W-1:0]         s1_lz;

    leading_zero_counter #(.DATA_W(PROD_W)) u_lzc (
        .data  (in_mant),
        .count (lz_in)
    );

    assign cls_in = (cls_e'(in_class) == CLS_NORMAL && in_mant == '0) ? CLS_ZERO : cls_e'(in_class);

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_sign <= in_sign;
            s1_exp  <= in_exp;
            s1_mant <= in_mant;
            s1_cls  <= cls_in;
            s1_rnd  <= rnd_e'(in_rnd);
            s1_lz   <= lz_in;
        end
    end

    // ---------------- S2 ----------------
    logic signed [IW-1:0]    ex, lz_s, e_norm, s2_exp_d, s2_exp;
    logic [RS_W-1:0]         rs;
    logic [2*PROD_W:0]       wide;
    logic [PROD_W-1:0]       s2_mant_d, s2_mant;
    logic                    s2_sticky_d, s2_sticky, s2_sign;
    cls_e                    s2_cls;
    rnd_e                    s2_rnd;

    assign ex     = {s1_exp[EW-1], s1_exp};
    assign lz_s   = IW'(s1_lz);
    assign e_norm = ex + IW'(1) - lz_s;

    always_comb begin
        s2_mant_d   = s1_mant;
        s2_sticky_d = 1'b0;
        s2_exp_d    = '0;
        rs          = '0;
        wide        = '0;
        if (ex >= lz_s) begin
            s2_mant_d = s1_mant << s1_lz;
            s2_exp_d  = e_norm;
        end else if (ex >= 0) begin
            s2_mant_d = s1_mant << ex[LZ_W-1:0];
        end else begin
            rs = (ex < -(PROD_W + 1)) ? RS_W'(PROD_W + 1) : RS_W'(-ex);
            // Low half of the wide vector catches everything shifted past the LSB.
            wide        = {s1_mant, (PROD_W + 1)'(0)} >> rs;
            s2_mant_d   = wide[2*PROD_W -: PROD_W];
            s2_sticky_d = |wide[PROD_W:0];
        end
    end

    always_ff @(posedge clk) begin
        if (adv && vld_pipe[1]) begin
            s2_mant   <= s2_mant_d;
            s2_sticky <= s2_sticky_d;
            s2_exp    <= s2_exp_d;
            s2_sign   <= s1_sign;
            s2_cls    <= s1_cls;
            s2_rnd    <= s1_rnd;
        end
    end

    // ---------------- S3 ----------------
    logic [FRAC_W:0]         keep;
    logic [FRAC_W+1:0]       sum;
    logic [FRAC_W-1:0]       frac_r;
    logic                    guard, sticky, inc, carry, bump, inexact, ovf, to_inf;
    logic signed [IW-1:0]    exp_r;
    logic [RES_W-1:0]        res_d;
    logic [3:0]              flg_d;

    assign keep    = s2_mant[PROD_W-1 -: FRAC_W+1];
    assign guard   = s2_mant[PROD_W-FRAC_W-2];
    assign sticky  = (|s2_mant[PROD_W-FRAC_W-3:0]) | s2_sticky;
    assign inexact = guard | sticky;

    always_comb begin
        unique case (s2_rnd)
            RND_RNE: inc = guard && (sticky || keep[0]);
            RND_RUP: inc = !s2_sign && inexact;
            RND_RDN: inc = s2_sign && inexact;
            default: inc = 1'b0;
        endcase
    end

    assign sum    = {1'b0, keep} + (FRAC_W + 2)'(inc);
    assign carry  = sum[FRAC_W+1];
    // A denormal that rounds into the hidden bit becomes the smallest normal.
    assign bump   = carry | (s2_exp == 0 && sum[FRAC_W]);
    assign exp_r  = s2_exp + IW'(bump);
    assign frac_r = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
    assign ovf    = exp_r >= MAX_E;
    assign to_inf = (s2_rnd == RND_RNE) || (s2_rnd == RND_RUP && !s2_sign) ||
                    (s2_rnd == RND_RDN && s2_sign);

    always_comb begin
        res_d = {s2_sign, exp_r[EXP_W-1:0], frac_r};
        flg_d = '0;
        if (ovf) begin
            res_d = to_inf ? {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                           : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
            flg_d[FLG_OVF] = 1'b1;
            flg_d[FLG_INX] = 1'b1;
        end else begin
            flg_d[FLG_INX]  = inexact;
            flg_d[FLG_UNF]  = (exp_r == 0) && inexact;
            flg_d[FLG_ZERO] = (exp_r == 0) && (frac_r == '0);
        end
        unique case (s2_cls)
            CLS_ZERO: begin
                res_d           = {s2_sign, {(RES_W-1){1'b0}}};
                flg_d           = '0;
                flg_d[FLG_ZERO] = 1'b1;
            end
            CLS_INF: begin
                res_d = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                flg_d = '0;
            end
            CLS_NAN: begin
                res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                flg_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_result <= '0;
            out_flags  <= '0;
        end else if (adv && vld_pipe[STAGES-1]) begin
            out_result <= res_d;
            out_flags  <= flg_d;
        end
    end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Table-driven scoreboard bench for fp_norm_round_pipe at EXP_W=8, FRAC_W=23.
module tb_fp_norm_round_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic [1:0]  in_class = '0;
    logic [1:0]  in_rnd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    always #5 clk = ~clk;

    fp_norm_round_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_class   (in_class),
        .in_rnd     (in_rnd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    typedef struct {
        string       name;
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic [1:0]  cls;
        logic [1:0]  rnd;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    vec_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input string nm, input logic s, input logic [9:0] e,
                                input logic [47:0] m, input logic [1:0] c, input logic [1:0] r,
                                input logic [31:0] res, input logic [3:0] f);
        vec_t v;
        v.name = nm; v.sign = s; v.exp = e; v.mant = m; v.cls = c; v.rnd = r;
        v.res = res; v.flg = f;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // Scoreboard push on accept, pop/compare on output, and hold-stability under stall.
    logic        prev_stall = 1'b0;
    logic        prev_rst   = 1'b1;
    logic [31:0] prev_res;
    logic [3:0]  prev_flg;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && in_valid && in_ready) sb.push_back('{cur.name, cur.res, cur.flg});
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h/%b, want no output", out_result, out_flags);
            end else begin
                e = sb.pop_front();
                if (out_result !== e.res || out_flags !== e.flg) begin
                    n_fail++;
                    $display("FAIL %s: got %h/%b, want %h/%b", e.name, out_result, out_flags, e.res, e.flg);
                end
            end
        end
        if (prev_stall && !prev_rst) begin
            n_tests++;
            if (!out_valid || out_result !== prev_res || out_flags !== prev_flg) begin
                n_fail++;
                $display("FAIL stall_hold: got v%0b %h/%b, want v1 %h/%b",
                         out_valid, out_result, out_flags, prev_res, prev_flg);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_rst   = rst;
        prev_res   = out_result;
        prev_flg   = out_flags;
    end

    task automatic send(input vec_t v);
        bit acc = 0;
        cur = v;
        in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
        in_class = v.cls; in_rnd = v.rnd; in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout %s: got in_ready 0, want 1", v.name);
        end
    endtask

    task automatic drain();
        int k = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        tbl.push_back(mk("t1_basic",     0, 10'd127, 48'h900000000000, 2'b00, 2'b00, 32'h40100000, 4'b0000));
        tbl.push_back(mk("t2_tie_carry", 0, 10'd127, 48'h7FFFFFC00000, 2'b00, 2'b00, 32'h40000000, 4'b0010));
        tbl.push_back(mk("t3_ovf_rne",   0, 10'd255, 48'h400000000000, 2'b00, 2'b00, 32'h7F800000, 4'b1010));
        tbl.push_back(mk("t3_ovf_rtz",   0, 10'd255, 48'h400000000000, 2'b00, 2'b01, 32'h7F7FFFFF, 4'b1010));
        tbl.push_back(mk("t4_denorm",    0, 10'h3FF, 48'h400000000000, 2'b00, 2'b00, 32'h00200000, 4'b0000));
        tbl.push_back(mk("t4_denorm_ix", 0, 10'h3FF, 48'h400000000001, 2'b00, 2'b00, 32'h00200000, 4'b0110));
        tbl.push_back(mk("t5_zero",      1, 10'd0,   48'h0,            2'b01, 2'b00, 32'h80000000, 4'b0001));
        tbl.push_back(mk("t5_inf",       0, 10'd0,   48'h0,            2'b10, 2'b00, 32'h7F800000, 4'b0000));
        tbl.push_back(mk("t5_nan",       1, 10'd5,   48'h123,          2'b11, 2'b00, 32'h7FC00000, 4'b0000));
        tbl.push_back(mk("mant0_zero",   1, 10'd100, 48'h0,            2'b00, 2'b00, 32'h80000000, 4'b0001));
        tbl.push_back(mk("neg_inf",      1, 10'd0,   48'h0,            2'b10, 2'b01, 32'hFF800000, 4'b0000));
        tbl.push_back(mk("rup_pos",      0, 10'd127, 48'h400000000001, 2'b00, 2'b10, 32'h3F800001, 4'b0010));
        tbl.push_back(mk("rdn_pos",      0, 10'd127, 48'h400000000001, 2'b00, 2'b11, 32'h3F800000, 4'b0010));
        tbl.push_back(mk("rdn_neg",      1, 10'd127, 48'h400000000001, 2'b00, 2'b11, 32'hBF800001, 4'b0010));
        tbl.push_back(mk("rtz_neg",      1, 10'd127, 48'h400000000001, 2'b00, 2'b01, 32'hBF800000, 4'b0010));
        tbl.push_back(mk("rne_sticky",   0, 10'd127, 48'h400000000001, 2'b00, 2'b00, 32'h3F800000, 4'b0010));
        tbl.push_back(mk("rne_tie_even", 0, 10'd127, 48'h400000400000, 2'b00, 2'b00, 32'h3F800000, 4'b0010));
        tbl.push_back(mk("ovf_rdn_pos",  0, 10'd255, 48'h400000000000, 2'b00, 2'b11, 32'h7F7FFFFF, 4'b1010));
        tbl.push_back(mk("ovf_rup_neg",  1, 10'd255, 48'h400000000000, 2'b00, 2'b10, 32'hFF7FFFFF, 4'b1010));
        tbl.push_back(mk("ovf_rdn_neg",  1, 10'd255, 48'h400000000000, 2'b00, 2'b11, 32'hFF800000, 4'b1010));
        tbl.push_back(mk("max_exp_254",  0, 10'd254, 48'h400000000000, 2'b00, 2'b00, 32'h7F000000, 4'b0000));
        tbl.push_back(mk("carry_to_ovf", 0, 10'd254, 48'h7FFFFFC00000, 2'b00, 2'b00, 32'h7F800000, 4'b1010));
        tbl.push_back(mk("exp_511_rtz",  0, 10'h1FF, 48'h900000000000, 2'b00, 2'b01, 32'h7F7FFFFF, 4'b1010));
        tbl.push_back(mk("deep_rtz",     0, 10'h39C, 48'h400000000000, 2'b00, 2'b01, 32'h00000000, 4'b0111));
        tbl.push_back(mk("deep_rup",     0, 10'h39C, 48'h400000000000, 2'b00, 2'b10, 32'h00000001, 4'b0110));
        tbl.push_back(mk("exp_m512",     0, 10'h200, 48'h400000000000, 2'b00, 2'b00, 32'h00000000, 4'b0111));
        tbl.push_back(mk("denorm_to_nrm",0, 10'd0,   48'h7FFFFF800000, 2'b00, 2'b00, 32'h00800000, 4'b0010));
        tbl.push_back(mk("partial_shift",0, 10'd2,   48'h010000000000, 2'b00, 2'b00, 32'h00040000, 4'b0000));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_result", out_result,      32'd0);
        check("rst_out_flags",  32'(out_flags),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Latency with an empty pipe
        send(tbl[0]);
        in_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        drain();

        // Full table, back to back
        foreach (tbl[i]) send(tbl[i]);
        drain();

        // Stall: three in flight, a fourth offered, out_ready low 4 cycles
        out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[4]);
        send(tbl[11]);
        cur = tbl[2];
        in_sign = cur.sign; in_exp = cur.exp; in_mant = cur.mant;
        in_class = cur.cls; in_rnd = cur.rnd; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(tbl[2]);
        drain();

        // Reset with valids in flight
        out_ready = 1'b0;
        send(tbl[5]);
        send(tbl[6]);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid",  32'(out_valid), 32'd0);
        check("flush_out_result", out_result,     32'd0);
        out_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        send(tbl[7]);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
